icb_apb_bridge: RTL

Single-slave ICB-to-APB3 bridge that sits directly downstream of one slave port of the 2-master/8-slave ICB bus. It accepts one ICB command at a time, runs it as an APB3 SETUP/ACCESS transfer to low-speed peripherals, and returns ICB responses for reads only, matching the bus's read-only response routing. An ACCESS-phase watchdog aborts hung transfers and flags them as errors.

---
 rtl/icb_apb_bridge.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/icb_apb_bridge.sv
// icb_apb_bridge
//   Single-slave ICB to APB3 bridge. Accepts one ICB command at a time and
//   runs it as an APB3 SETUP/ACCESS transfer. Only reads return an ICB
//   response. Write errors are signalled only through bus_err. An
//   ACCESS-phase watchdog aborts transfers whose slave never raises pready.
//
// Parameters
//   ADDR_W       APB address width (paddr = icb_cmd_addr[ADDR_W-1:0])
//   TIMEOUT_CYC  watchdog limit in ACCESS cycles; 0 disables the watchdog
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   icb_cmd_*           ICB command channel (valid/ready, addr, read, wdata, wmask)
//   icb_rsp_*           ICB read response channel (valid/ready, err, rdata)
//   paddr..pstrb        registered APB3 master outputs
//   prdata/pready/pslverr  APB3 slave returns
//   bus_err             one-cycle pulse after any errored or timed-out transfer
module icb_apb_bridge #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [31:0]       icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [31:0]       icb_cmd_wdata,
  input  logic [3:0]        icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic              icb_rsp_err,
  output logic [31:0]       icb_rsp_rdata,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RSP    = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);
  localparam bit          WD_EN       = (TIMEOUT_CYC != 0);

  state_t      state;
  logic [15:0] wd_cnt;

  // Address bits above ADDR_W are intentionally ignored.
  logic addr_unused;
  assign addr_unused = ^icb_cmd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wd_cnt        <= 16'd0;
      icb_cmd_ready <= 1'b0;
      icb_rsp_valid <= 1'b0;
      icb_rsp_err   <= 1'b0;
      icb_rsp_rdata <= 32'd0;
      paddr         <= '0;
      psel          <= 1'b0;
      penable       <= 1'b0;
      pwrite        <= 1'b0;
      pwdata        <= 32'd0;
      pstrb         <= 4'd0;
      bus_err       <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          // cmd_ready is registered, so it rises one clock after reset
          // releases and drops in the same edge that accepts a command.
          if (icb_cmd_valid && icb_cmd_ready) begin
            icb_cmd_ready <= 1'b0;
            paddr         <= icb_cmd_addr[ADDR_W-1:0];
            pwrite        <= ~icb_cmd_read;
            pwdata        <= icb_cmd_wdata;
            pstrb         <= icb_cmd_read ? 4'b0000 : icb_cmd_wmask;
            psel          <= 1'b1;
            penable       <= 1'b0;
            state         <= SETUP;
          end else begin
            icb_cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          wd_cnt  <= 16'd0;
          state   <= ACCESS;
        end

        ACCESS: begin
          // pready wins over a watchdog expiry in the same cycle.
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            bus_err <= pslverr;
            if (!pwrite) begin
              icb_rsp_rdata <= prdata;
              icb_rsp_err   <= pslverr;
              icb_rsp_valid <= 1'b1;
              state         <= RSP;
            end else begin
              icb_cmd_ready <= 1'b1;
              state         <= IDLE;
            end
          end else if (WD_EN && (wd_cnt == TIMEOUT_LIM)) begin
            // Abort: reads answer with an error, writes are dropped.
            psel    <= 1'b0;
            penable <= 1'b0;
            bus_err <= 1'b1;
            if (!pwrite) begin
              icb_rsp_rdata <= 32'd0;
              icb_rsp_err   <= 1'b1;
              icb_rsp_valid <= 1'b1;
              state         <= RSP;
            end else begin
              icb_cmd_ready <= 1'b1;
              state         <= IDLE;
            end
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end

        RSP: begin
          if (icb_rsp_ready) begin
            icb_rsp_valid <= 1'b0;
            icb_cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
